// File: rtl/hamming74_frame_decoder.sv
// hamming74_frame_decoder
// Decodes a 28-bit frame from noise_channel as four Hamming(7,4) codewords,
// one codeword per clock, correcting single-bit errors in each codeword.
// Presents a 16-bit payload, per-codeword correction flags and a saturating
// cumulative count of corrected codewords for BER measurement.
//
// Codeword bit map (b0..b6): p1, p2, d1, p4, d2, d3, d4.
// Double errors are miscorrected without indication.

module hamming74_frame_decoder #(
    parameter int unsigned NUM_CW = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  channel_done,
    input  logic [7*NUM_CW-1:0]   data_in,
    output logic [4*NUM_CW-1:0]   data_out,
    output logic                  decode_done,
    output logic [NUM_CW-1:0]     err_flags,
    output logic [CNT_W-1:0]      err_count,
    output logic                  busy
);

    localparam int unsigned IDX_W = (NUM_CW > 1) ? $clog2(NUM_CW) : 1;
    localparam int unsigned POP_W = $clog2(NUM_CW + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Control and datapath registers
    state_t                state_q;
    logic                  chd_q;
    logic [7*NUM_CW-1:0]   frame_q;
    logic [IDX_W-1:0]      idx_q;
    logic [4*NUM_CW-1:0]   pay_q;
    logic [NUM_CW-1:0]     flg_q;

    // Registered outputs
    logic [4*NUM_CW-1:0]   data_out_q;
    logic [NUM_CW-1:0]     err_flags_q;
    logic [CNT_W-1:0]      err_count_q;
    logic                  decode_done_q;
    logic                  busy_q;

    // Combinational next-values
    logic                  start_d;
    logic                  last_d;
    logic [6:0]            cw_d;
    logic [2:0]            syn_d;
    logic [3:0]            nib_d;
    logic                  flag_d;
    logic [POP_W-1:0]      pop_d;
    logic [CNT_W:0]        sum_d;
    logic [CNT_W-1:0]      cnt_d;

    assign data_out    = data_out_q;
    assign err_flags   = err_flags_q;
    assign err_count   = err_count_q;
    assign decode_done = decode_done_q;
    assign busy        = busy_q;

    // Start is a rising edge of channel_done seen while idle
    always_comb begin
        start_d = (state_q == IDLE) && channel_done && !chd_q;
        last_d  = (idx_q == IDX_W'(NUM_CW - 1));
    end

    // Select the codeword addressed by idx from the latched frame
    always_comb begin
        cw_d = '0;
        for (int unsigned i = 0; i < NUM_CW; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cw_d = frame_q[7*i +: 7];
            end
        end
    end

    // Syndrome and corrected nibble for the selected codeword.
    // Only data-bit positions (3, 5, 6, 7) change the nibble; a syndrome
    // pointing at a parity bit leaves the payload untouched but still flags.
    always_comb begin
        syn_d[0] = cw_d[0] ^ cw_d[2] ^ cw_d[4] ^ cw_d[6];
        syn_d[1] = cw_d[1] ^ cw_d[2] ^ cw_d[5] ^ cw_d[6];
        syn_d[2] = cw_d[3] ^ cw_d[4] ^ cw_d[5] ^ cw_d[6];
        flag_d   = (syn_d != 3'd0);
        nib_d[0] = cw_d[2] ^ (syn_d == 3'd3);
        nib_d[1] = cw_d[4] ^ (syn_d == 3'd5);
        nib_d[2] = cw_d[5] ^ (syn_d == 3'd6);
        nib_d[3] = cw_d[6] ^ (syn_d == 3'd7);
    end

    // Saturating update of the corrected-codeword counter from scratch flags
    always_comb begin
        pop_d = '0;
        for (int unsigned i = 0; i < NUM_CW; i++) begin
            pop_d = pop_d + POP_W'(flg_q[i]);
        end
        sum_d = {1'b0, err_count_q} + (CNT_W + 1)'(pop_d);
        cnt_d = sum_d[CNT_W] ? '1 : sum_d[CNT_W-1:0];
    end

    // Decoder FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            chd_q         <= 1'b0;
            frame_q       <= '0;
            idx_q         <= '0;
            pay_q         <= '0;
            flg_q         <= '0;
            data_out_q    <= '0;
            err_flags_q   <= '0;
            err_count_q   <= '0;
            decode_done_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            chd_q         <= channel_done;
            decode_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_d) begin
                        frame_q <= data_in;
                        flg_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    for (int unsigned i = 0; i < NUM_CW; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            pay_q[4*i +: 4] <= nib_d;
                            flg_q[i]        <= flag_d;
                        end
                    end
                    idx_q <= idx_q + 1'b1;
                    if (last_d) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    data_out_q    <= pay_q;
                    err_flags_q   <= flg_q;
                    err_count_q   <= cnt_d;
                    decode_done_q <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamming74_frame_decoder.sv
// Scoreboard bench for hamming74_frame_decoder: directed frames push their
// hand-computed expected payload/flags/count; a monitor pops on decode_done.

module tb_hamming74_frame_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        channel_done = 1'b0;
    logic [27:0] data_in = '0;
    logic [15:0] data_out;
    logic        decode_done;
    logic [3:0]  err_flags;
    logic [7:0]  err_count;
    logic        busy;

    hamming74_frame_decoder #(
        .NUM_CW(4),
        .CNT_W (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .channel_done(channel_done),
        .data_in     (data_in),
        .data_out    (data_out),
        .decode_done (decode_done),
        .err_flags   (err_flags),
        .err_count   (err_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  f;
        logic [7:0]  c;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned pulses = 0;
    logic [7:0]  model_cnt = '0;
    logic        prev_dd = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] sat_add(input logic [7:0] c, input logic [3:0] f);
        int s;
        s = int'(c) + $countones(f);
        return (s > 255) ? 8'hFF : 8'(s);
    endfunction

    task automatic push_exp(input logic [15:0] d, input logic [3:0] f);
        exp_t e;
        model_cnt = sat_add(model_cnt, f);
        e.d = d;
        e.f = f;
        e.c = model_cnt;
        sb_q.push_back(e);
    endtask

    // Monitor: compare every decode_done against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (decode_done) begin
            pulses++;
            check("pulse_width", 32'(prev_dd), 32'd0);
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got data_out %0h with no expected entry", data_out);
            end else begin
                e = sb_q.pop_front();
                check("data_out", 32'(data_out), 32'(e.d));
                check("err_flags", 32'(err_flags), 32'(e.f));
                check("err_count", 32'(err_count), 32'(e.c));
            end
        end
        prev_dd = decode_done;
    end

    // Wait for decode_done; expects it at the 6th falling edge after raising
    task automatic wait_pulse(input string name);
        int k;
        for (k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (decode_done) break;
        end
        check({name, "_latency"}, 32'(k), 32'd6);
    endtask

    task automatic run_frame(input logic [27:0] din, input logic [15:0] d,
                             input logic [3:0] f, input string name);
        push_exp(d, f);
        data_in      = din;
        channel_done = 1'b1;
        wait_pulse(name);
        channel_done = 1'b0;
        @(negedge clk);
        check({name, "_hold"}, 32'(data_out), 32'(d));
    endtask

    initial begin
        int unsigned p0;

        // Reset state
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_flags", 32'(err_flags), 32'd0);
        check("rst_count", 32'(err_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(decode_done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean, all-ones and all-zeros frames
        run_frame(28'h5555555, 16'h4B4B, 4'b0000, "clean");
        run_frame(28'hFFFFFFF, 16'hFFFF, 4'b0000, "ones");
        run_frame(28'h0000000, 16'h0000, 4'b0000, "zeros");

        // Single-error correction in one codeword
        run_frame(28'h0000004, 16'h0000, 4'b0001, "err_cw0_d1");
        run_frame(28'h7FFFFFF, 16'hFFFF, 4'b1000, "err_cw3_d4");
        // Error in a parity bit: payload untouched, flag set
        run_frame(28'h0000080, 16'h0000, 4'b0010, "err_cw1_p1");
        check("count_after_singles", 32'(err_count), 32'd3);

        // Level held high for 20000 ns gives one decode only
        p0 = pulses;
        push_exp(16'h4B4B, 4'b0000);
        data_in      = 28'h5555555;
        channel_done = 1'b1;
        repeat (2000) @(negedge clk);
        check("held_single_pulse", pulses - p0, 32'd1);
        channel_done = 1'b0;
        @(negedge clk);

        // A rising edge while busy is ignored and not queued
        p0 = pulses;
        push_exp(16'h0000, 4'b0000);
        data_in      = 28'h0000000;
        channel_done = 1'b1;
        repeat (2) @(negedge clk);
        check("busy_in_decode", 32'(busy), 32'd1);
        channel_done = 1'b0;
        @(negedge clk);
        channel_done = 1'b1;
        repeat (20) @(negedge clk);
        check("retrigger_single_pulse", pulses - p0, 32'd1);
        channel_done = 1'b0;
        @(negedge clk);

        // Saturation: every codeword carries one error
        for (int i = 0; i < 64; i++) begin
            run_frame(28'h0204081, 16'h0000, 4'b1111, "sat");
        end
        check("sat_final", 32'(err_count), 32'hFF);

        // Reset mid-decode aborts without a pulse; held level restarts
        p0 = pulses;
        data_in      = 28'h5555555;
        channel_done = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_data_out", 32'(data_out), 32'd0);
        check("abort_flags", 32'(err_flags), 32'd0);
        check("abort_count", 32'(err_count), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(decode_done), 32'd0);
        model_cnt = '0;
        repeat (3) @(negedge clk);
        check("abort_no_pulse", pulses - p0, 32'd0);
        push_exp(16'h4B4B, 4'b0000);
        rst_n = 1'b1;
        wait_pulse("restart");
        channel_done = 1'b0;
        repeat (3) @(negedge clk);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
